// File: rtl/alu_ctrl.sv
// Three-phase instruction controller for a 4-bit ALU: accepts one instruction,
// issues registered operands, writes back the result and pulses done.
module alu_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] instr,
    output logic       done,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [1:0] alu_op,
    output logic       alu_l,
    input  logic [3:0] alu_r,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_s,
    output logic [3:0] acc,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_s,
    output logic [7:0] ops_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] KIND_ALU = 2'b00;
    localparam logic [1:0] KIND_LDI = 2'b01;
    localparam logic [1:0] KIND_STR = 2'b10;
    localparam logic [1:0] KIND_LDR = 2'b11;

    logic [1:0] r_state;
    logic [9:0] r_instr;
    logic [3:0] r_acc;
    logic [3:0] r_regs [4];
    logic       r_z;
    logic       r_c;
    logic       r_s;
    logic [7:0] r_ops_cnt;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic       r_alu_cin;
    logic [1:0] r_alu_op;
    logic       r_alu_l;

    logic       w_accept;
    logic [1:0] w_kind;
    logic [1:0] w_rsel;
    logic [3:0] w_imm;
    logic [3:0] w_reg_val;

    assign in_ready  = (r_state == ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign w_accept  = in_ready && in_valid;
    assign w_kind    = r_instr[9:8];
    assign w_rsel    = r_instr[1:0];
    assign w_imm     = r_instr[3:0];
    assign w_reg_val = r_regs[w_rsel];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_instr   <= '0;
            r_acc     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_s       <= 1'b0;
            r_ops_cnt <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_cin <= 1'b0;
            r_alu_op  <= '0;
            r_alu_l   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Operands are captured here and held for the whole instruction.
                        r_instr   <= instr;
                        r_alu_a   <= r_acc;
                        r_alu_b   <= r_regs[instr[1:0]];
                        r_alu_l   <= instr[7];
                        r_alu_op  <= instr[6:5];
                        r_alu_cin <= instr[4] ? r_c : 1'b0;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (w_kind)
                        KIND_ALU: begin
                            r_acc <= alu_r;
                            r_z   <= alu_z;
                            r_s   <= alu_s;
                            // Logic ops leave carry alone.
                            if (!r_instr[7]) begin
                                r_c <= alu_c;
                            end
                        end
                        KIND_LDI: begin
                            r_acc <= w_imm;
                            r_z   <= (w_imm == 4'd0);
                            r_s   <= w_imm[3];
                        end
                        KIND_STR: begin
                            r_regs[w_rsel] <= r_acc;
                        end
                        KIND_LDR: begin
                            r_acc <= w_reg_val;
                            r_z   <= (w_reg_val == 4'd0);
                            r_s   <= w_reg_val[3];
                        end
                        default: ;
                    endcase
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_ops_cnt <= r_ops_cnt + 8'd1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_cin = r_alu_cin;
    assign alu_op  = r_alu_op;
    assign alu_l   = r_alu_l;
    assign acc     = r_acc;
    assign flag_z  = r_z;
    assign flag_c  = r_c;
    assign flag_s  = r_s;
    assign ops_cnt = r_ops_cnt;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural model of the 4-bit ALU on its alu_* ports.
module tb_alu_ctrl;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] instr;
    logic       done;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [1:0] alu_op;
    logic       alu_l;
    logic [3:0] alu_r;
    logic       alu_z;
    logic       alu_c;
    logic       alu_s;
    logic [3:0] acc;
    logic       flag_z;
    logic       flag_c;
    logic       flag_s;
    logic [7:0] ops_cnt;

    int errors;
    int checks;

    alu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .done     (done),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_op   (alu_op),
        .alu_l    (alu_l),
        .alu_r    (alu_r),
        .alu_z    (alu_z),
        .alu_c    (alu_c),
        .alu_s    (alu_s),
        .acc      (acc),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_s   (flag_s),
        .ops_cnt  (ops_cnt)
    );

    // Team ALU: arithmetic carry is bit 4 of the 5-bit sum; logic ops report no carry.
    logic [4:0] w_sum;
    always_comb begin
        w_sum = 5'd0;
        if (!alu_l) begin
            case (alu_op)
                2'b00:   w_sum = {1'b0, alu_a} + {4'd0, alu_cin};
                2'b01:   w_sum = {1'b0, ~alu_a} + 5'd1 + {4'd0, alu_cin};
                2'b10:   w_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
                default: w_sum = {1'b0, alu_a} + 5'd1 + {4'd0, alu_cin};
            endcase
        end else begin
            case (alu_op)
                2'b00:   w_sum = {1'b0, alu_a & alu_b};
                2'b01:   w_sum = {1'b0, alu_a | alu_b};
                2'b10:   w_sum = {1'b0, alu_a ^ alu_b};
                default: w_sum = {1'b0, ~alu_a};
            endcase
        end
        alu_r = w_sum[3:0];
        alu_c = w_sum[4];
        alu_z = (w_sum[3:0] == 4'd0);
        alu_s = w_sum[3];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, then presents instruction for exactly one accept edge.
    task automatic issue(input logic [9:0] ins);
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL issue_wait: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1;
        instr    = ins;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run(input logic [9:0] ins);
        issue(ins);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        instr    = '0;
        do_reset();
        checks++;
        if ({acc, flag_z, flag_c, flag_s} !== 7'd0) begin
            errors++;
            $display("FAIL reset_state: acc/z/c/s=%b required 0000000", {acc, flag_z, flag_c, flag_s});
        end
        checks++;
        if ({ops_cnt, done, in_ready} !== 10'b0000_0000_01) begin
            errors++;
            $display("FAIL reset_ctrl: ops/done/rdy=%b required 0000000001", {ops_cnt, done, in_ready});
        end
        checks++;
        if ({alu_a, alu_b, alu_cin, alu_op, alu_l} !== 12'd0) begin
            errors++;
            $display("FAIL reset_alu: alu_*=%b required 0", {alu_a, alu_b, alu_cin, alu_op, alu_l});
        end
    endtask

    task automatic test_ldi();
        issue(10'b01_0_00_0_0101);
        checks++;
        if ({done, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL ldi_exec: done/rdy=%b required 00", {done, in_ready});
        end
        tick();
        checks++;
        if ({acc, flag_z, flag_s, flag_c, done} !== 8'b0101_0001) begin
            errors++;
            $display("FAIL ldi_wb: acc/z/s/c/done=%b required 01010001", {acc, flag_z, flag_s, flag_c, done});
        end
        tick();
        checks++;
        if ({done, in_ready, ops_cnt} !== {2'b01, 8'd1}) begin
            errors++;
            $display("FAIL ldi_retire: done/rdy/ops=%b required 0100000001", {done, in_ready, ops_cnt});
        end
    endtask

    task automatic test_alu_arith();
        run(10'b01_0_00_0_0001);
        run(10'b10_0_00_0_0001);
        run(10'b01_0_00_0_1111);
        issue(10'b00_0_10_0_0001);
        checks++;
        if ({alu_a, alu_b, alu_l, alu_op, alu_cin} !== {4'b1111, 4'b0001, 1'b0, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL add_operands: a/b/l/op/cin=%b required 111100010100", {alu_a, alu_b, alu_l, alu_op, alu_cin});
        end
        tick();
        tick();
        checks++;
        if ({acc, flag_z, flag_c, flag_s} !== 7'b0000_110) begin
            errors++;
            $display("FAIL add_wrap: acc/z/c/s=%b required 0000110", {acc, flag_z, flag_c, flag_s});
        end
        issue(10'b00_0_00_1_0000);
        checks++;
        if (alu_cin !== 1'b1) begin
            errors++;
            $display("FAIL inc_cin: alu_cin=%b required 1", alu_cin);
        end
        tick();
        tick();
        checks++;
        if ({acc, flag_z, flag_c, flag_s} !== 7'b0001_000) begin
            errors++;
            $display("FAIL inc_cin_result: acc/z/c/s=%b required 0001000", {acc, flag_z, flag_c, flag_s});
        end
        // Negate 0001 with unused bits [3:2] set: 1111, no carry, negative.
        run(10'b00_0_01_0_1100);
        checks++;
        if ({acc, flag_z, flag_c, flag_s} !== 7'b1111_001) begin
            errors++;
            $display("FAIL negate: acc/z/c/s=%b required 1111001", {acc, flag_z, flag_c, flag_s});
        end
        checks++;
        if (alu_b !== 4'b0000) begin
            errors++;
            $display("FAIL unused_bits_rsel: alu_b=%b required 0000", alu_b);
        end
    endtask

    task automatic test_alu_logic();
        run(10'b01_0_00_0_1111);
        run(10'b00_0_11_0_0000);
        run(10'b01_0_00_0_0101);
        checks++;
        if ({acc, flag_c} !== 5'b0101_1) begin
            errors++;
            $display("FAIL logic_setup: acc/c=%b required 01011", {acc, flag_c});
        end
        run(10'b00_1_11_0_0000);
        checks++;
        if ({acc, flag_s, flag_z, flag_c} !== 7'b1010_101) begin
            errors++;
            $display("FAIL not_keeps_c: acc/s/z/c=%b required 1010101", {acc, flag_s, flag_z, flag_c});
        end
        // alu_* must still show the NOT operands after retirement.
        checks++;
        if ({alu_a, alu_l, alu_op} !== 7'b0101_111) begin
            errors++;
            $display("FAIL alu_hold: a/l/op=%b required 0101111", {alu_a, alu_l, alu_op});
        end
    endtask

    task automatic test_mov();
        run(10'b01_0_00_0_0000);
        run(10'b11_0_00_0_0001);
        checks++;
        if ({acc, flag_z, flag_s} !== 6'b0001_00) begin
            errors++;
            $display("FAIL mov_r1_to_acc: acc/z/s=%b required 000100", {acc, flag_z, flag_s});
        end
        run(10'b11_0_00_0_0010);
        checks++;
        if ({acc, flag_z, flag_s} !== 6'b0000_10) begin
            errors++;
            $display("FAIL mov_r2_to_acc: acc/z/s=%b required 000010", {acc, flag_z, flag_s});
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] ops_before;
        ops_before = ops_cnt;
        issue(10'b01_0_00_0_0111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({done, in_ready, acc, ops_cnt} !== {2'b01, 4'b0000, 8'd0}) begin
            errors++;
            $display("FAIL abort_exec: done/rdy/acc/ops=%b required 01000000000000 (ops before %0d)",
                     {done, in_ready, acc, ops_cnt}, ops_before);
        end
        tick();
        checks++;
        if ({done, acc} !== 5'b0_0000) begin
            errors++;
            $display("FAIL abort_after: done/acc=%b required 00000", {done, acc});
        end
        // Reset wins over a simultaneous accept.
        run(10'b01_0_00_0_1001);
        reset    = 1'b1;
        in_valid = 1'b1;
        instr    = 10'b00_0_10_1_0000;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, alu_a, alu_op, acc} !== {1'b1, 4'd0, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_priority: rdy/a/op/acc=%b required 10000000000", {in_ready, alu_a, alu_op, acc});
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int dones;
        accepts = 0;
        dones   = 0;
        do_reset();
        in_valid = 1'b1;
        instr    = 10'b01_0_00_0_0011;
        for (int i = 0; i < 768; i++) begin
            if (in_ready && in_valid) accepts++;
            tick();
            if (done) dones++;
        end
        in_valid = 1'b0;
        checks++;
        if (accepts !== 256) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d required 256", accepts);
        end
        checks++;
        if (dones !== 256) begin
            errors++;
            $display("FAIL b2b_dones: got %0d required 256", dones);
        end
        checks++;
        if ({ops_cnt, acc, in_ready} !== {8'd0, 4'b0011, 1'b1}) begin
            errors++;
            $display("FAIL ops_wrap: ops/acc/rdy=%b required 0000000000111", {ops_cnt, acc, in_ready});
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        instr    = '0;
        #1;
        test_reset();
        test_ldi();
        test_alu_arith();
        test_alu_logic();
        test_mov();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
